nn_mac_neuron: RTL
==================

// Module: nn_mac_neuron
// PURPOSE
//  Parametrised streaming neuron: accumulates N_IN signed din*w products plus a bias,
//  rescales by an arithmetic right shift, optionally applies ReLU, saturates to DATA_W.
//  Valid/ready on input and output; sits behind the tt_um_* pin wrapper, in place of
//  the single-MAC top layer.
// PARAMETERS
//  DATA_W  8   width of din, w, bias, out_data (signed two's complement)
//  N_IN    4   products per output sample; N_IN >= 1
//  SHIFT   4   right shift applied to accumulator before saturation; 0..ACC_W-DATA_W
//  ACC_W   24  accumulator width; must be >= 2*DATA_W+$clog2(N_IN)+SHIFT+1
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       synchronous reset, active-high
//  flush      in   1       synchronous abort of a partial accumulation
//  in_valid   in   1       din/w/bias beat valid
//  in_ready   out  1       beat accepted when in_valid & in_ready
//  din        in   DATA_W  signed activation
//  w          in   DATA_W  signed weight
//  bias       in   DATA_W  signed bias; sampled on the first beat of each sample only
//  out_valid  out  1       out_data holds a result
//  out_ready  in   1       consumer accepts when out_valid & out_ready
//  out_data   out  DATA_W  signed result
//  busy       out  1       partial accumulation in progress (beat count != 0)
// BEHAVIOUR
//  - Reset (rst=1 at a clock edge): count=0, acc=0, out_valid=0, out_data=0, busy=0.
//    Dominates flush and all handshakes; a partial sample or pending result is discarded.
//  - in_ready = !out_valid | out_ready (combinational); asserted out of reset.
//  - Accepted beat, count==0: acc <= (sext(bias) <<< SHIFT) + din*w; count <= 1.
//  - Accepted beat, 0<count<N_IN-1: acc <= acc + din*w; count++.
//  - Accepted beat, count==N_IN-1 (also first beat when N_IN==1): count <= 0;
//    s = (acc_next >>> SHIFT) (floor); out_data <= sat(act(s)); out_valid <= 1.
//    Latency: result visible the cycle after the last beat is accepted.
//  - Products are full 2*DATA_W signed, sign-extended to ACC_W. The accumulator wraps
//    modulo 2^ACC_W; the ACC_W rule above guarantees no wrap in legal use.
//  - sat: clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
//  - out_valid clears on out_valid&out_ready unless a new result loads in the same
//    cycle (last beat accepted while draining) -> out_valid stays 1 with the new data.
//  - flush=1: count <= 0 and acc <= 0; any beat accepted in that cycle is dropped;
//    out_valid/out_data are unaffected (a completed result is never flushed).
//  - busy = (count != 0).
// CONFIGURATION
//  NN_MAC_RELU_EN defined: act(s) = (s < 0) ? 0 : s, applied before sat; out_data >= 0.
//  NN_MAC_RELU_EN undefined: act(s) = s (signed saturation only).
// STRUCTURE
//  - Package nn_pkg: default DATA_W/ACC_W localparams, function sat_signed(acc, w),
//    and an acc_t typedef for the ACC_W-wide signed accumulator.
//  - Sub-module nn_act_sat (combinational: shift, optional ReLU, saturate), reused by
//    later layers. Counter, accumulator and output register stay in nn_mac_neuron.
// TESTING  (DATA_W=8, N_IN=4, SHIFT=4, ACC_W=24)
//  1 bias=0, 4 beats din=16,w=16 -> acc 1024, out_data=64, out_valid 1 cycle after beat 4.
//  2 bias=2, 4 beats din=127,w=127 -> (32+64516)>>4=4034 -> out_data=127 (sat).
//  3 bias=0, 4 beats din=-128,w=127 -> -4064 -> -128 w/o RELU_EN; 0 with NN_MAC_RELU_EN.
//  4 out_ready=0 after result: in_ready=0, further beats stall, out_data held; release
//    out_ready with beat 4 of next sample valid -> back-to-back, out_valid stays 1.
//  5 2 beats din=10,w=10, then flush, then 4 beats din=1,w=16, bias=0 -> out_data=4.
//  6 rst=1 after 3 beats and with a pending result -> next cycle out_valid=0, busy=0,
//    out_data=0; next 4-beat sample yields a correct fresh result.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared neuron types and helpers: default widths, ACC_W-wide accumulator type,
// and signed saturation used by the activation stage.
package nn_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 24;

  typedef logic signed [ACC_W_DEF-1:0] acc_t;

  // Clamp v into the signed range of a w-bit two's complement value (w <= 63).
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                    input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/nn_act_sat.sv
// Combinational rescale (floor shift), optional ReLU, signed saturation to DATA_W.
// Zero latency, no flow control; ReLU enabled by defining NN_MAC_RELU_EN.
module nn_act_sat
  import nn_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int SHIFT  = 4
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [DATA_W-1:0] res
);

  logic signed [ACC_W-1:0] s;
  logic signed [ACC_W-1:0] a;

  assign s = acc >>> SHIFT;

`ifdef NN_MAC_RELU_EN
  assign a = (s < 0) ? '0 : s;
`else
  assign a = s;
`endif

  assign res = DATA_W'(sat_signed(64'(a), DATA_W));

endmodule

// File: rtl/nn_mac_neuron.sv
// Streaming neuron: N_IN din*w products plus shifted bias, rescaled and saturated.
// Result registered 1 cycle after last beat; in_ready = !out_valid | out_ready. ReLU via NN_MAC_RELU_EN.
module nn_mac_neuron
  import nn_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int N_IN   = 4,
  parameter int SHIFT  = 4,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] din,
  input  logic signed [DATA_W-1:0] w,
  input  logic signed [DATA_W-1:0] bias,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     busy
);

  localparam int CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;

  logic [CNT_W-1:0]          count;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   acc_base;
  logic signed [ACC_W-1:0]   acc_next;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [DATA_W-1:0]  res;
  logic                      accept;
  logic                      last;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign last     = (count == CNT_W'(N_IN - 1));
  assign busy     = (count != '0);

  assign prod     = (2*DATA_W)'(din) * (2*DATA_W)'(w);
  // The first beat of a sample replaces the accumulator with the scaled bias.
  assign acc_base = (count == '0) ? (ACC_W'(bias) <<< SHIFT) : acc;
  assign acc_next = acc_base + ACC_W'(prod);

  nn_act_sat #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .SHIFT  (SHIFT)
  ) u_act_sat (
    .acc (acc_next),
    .res (res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (flush) begin
        count <= '0;
        acc   <= '0;
      end else if (accept) begin
        acc <= acc_next;
        if (last) begin
          count     <= '0;
          out_data  <= res;
          out_valid <= 1'b1;
        end else begin
          count <= count + CNT_W'(1);
        end
      end
    end
  end

endmodule
